seven_segment_bcd_counter: RTL and testbench
============================================

Name: seven_segment_bcd_counter

Overview:
- Parametrised multi-digit BCD up/down counter driving DIGITS seven-segment displays. It is the generalised successor of the single-digit 1 Hz counter.
- A prescaler divides CLK_50 to a step tick. Each tick advances the counter by one.
- Adds enable, direction, synchronous clear, parallel load, optional leading-zero blanking and a wrap pulse.
- Top-level display block; HEX outputs go directly to board pins.

Parameters:
- DIGITS, 3: number of BCD digits and displays (1..8).
- TICK_DIV, 50000000: CLK_50 cycles per count step (>=1).
- BLANK_LEADING, 0: 1 turns off the segments of leading zero digits. Digit 0 is never blanked.

Ports:
- CLK_50  in  1  50 MHz system clock.
- RESET_N  in  1  asynchronous active-low reset.
- EN  in  1  1 lets the prescaler run and steps apply; 0 freezes both.
- UP_DN  in  1  1 counts up, 0 counts down.
- CLEAR  in  1  synchronous clear of count and prescaler.
- LOAD  in  1  synchronous load of LOAD_VAL.
- LOAD_VAL  in  4*DIGITS  BCD load value; digit 0 is bits [3:0].
- BCD_VAL  out  4*DIGITS  current registered BCD count.
- HEX  out  7*DIGITS  segment data. Digit k is [7k+6:7k]; bit0=a … bit6=g; active-high (1 = lit).
- TICK  out  1  one-cycle pulse on each step.
- WRAP  out  1  one-cycle pulse when a step wraps the count.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - prescaler=0, BCD_VAL=0, TICK=0, WRAP=0.
  - HEX shows "0" on every digit (7'b0111111); with BLANK_LEADING=1, digits 1..DIGITS-1 show 7'b0000000.
- Prescaler:
  - Range 0..TICK_DIV-1; increments only when EN=1.
  - When it equals TICK_DIV-1 with EN=1, it returns to 0 and a step occurs that cycle.
  - TICK is registered and asserts the cycle after the step, aligned with the new BCD_VAL.
- Priority per clock edge: CLEAR > LOAD > step.
  - CLEAR: BCD_VAL=0, prescaler=0, no TICK, no WRAP.
  - LOAD: BCD_VAL=LOAD_VAL, prescaler=0, no TICK, no WRAP. Any LOAD digit >9 is stored as 0.
  - CLEAR and LOAD ignore EN.
- Up step:
  - Digit 0 increments. A digit at 9 becomes 0 and carries into the next digit.
  - All digits at 9 -> all 0, and WRAP=1 for one cycle (aligned with TICK).
- Down step:
  - Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - All digits 0 -> all 9, and WRAP=1.
- UP_DN is sampled at the step cycle only. Changing it mid-period does not reset the prescaler.
- EN deasserted mid-period: prescaler holds and resumes from its held value.
- TICK_DIV=1: a step occurs every enabled cycle.
- Decode, per digit: combinational from BCD_VAL, same cycle as the register.
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Any other value -> 0000000.
- Leading-zero blanking (BLANK_LEADING=1): digit k>0 is blanked iff it and every higher digit are 0.
- Reset asserted mid-operation: immediate return to reset state. The first step after release occurs TICK_DIV enabled cycles later.

Decomposition:
- Shared package seg7_pkg:
  - constants SEG_0..SEG_9 and SEG_BLANK (7-bit patterns above);
  - BCD_MAX=4'd9;
  - function bcd_valid.
- One sub-module: seg7_decoder (4-bit BCD in, blank in, 7-bit segments out), instantiated DIGITS times via generate.
- Counter chain and prescaler stay in the top module.

Test Plan:
- Reset default: DIGITS=3, TICK_DIV=4. Release reset, hold EN=1, UP_DN=1 -> TICK pulses every 4 cycles; BCD_VAL 000,001,002…; HEX[6:0] follows 0111111, 0000110, 1011011.
- Up wrap: LOAD_VAL=12'h998, then count up. After 1 step -> 999; after 2 steps -> 000 with WRAP=1 for exactly one cycle, coincident with TICK.
- Down borrow/wrap: LOAD 100, UP_DN=0. 1 step -> 099; LOAD 000, 1 step -> 999 with WRAP=1.
- Priority: CLEAR=1 and LOAD=1 on the same edge as a step -> BCD_VAL=000, TICK=0, WRAP=0. LOAD of 12'h0A5 -> BCD_VAL=005.
- Enable and reset mid-period: EN low for 10 cycles mid-period -> no TICK, prescaler resumes. Assert RESET_N low asynchronously between edges -> outputs clear immediately.
- Blanking: BLANK_LEADING=1, value 007 -> HEX digits 2,1 = 0000000, digit 0 = 0000111. Value 000 -> digit 0 = 0111111, others blank.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment patterns and BCD helpers
// Purpose: segment constants (bit0=a .. bit6=g, active-high), BCD limit and
//          digit validity check shared by the counter and the decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic bcd_valid(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - one BCD digit to seven-segment pattern
// Purpose: combinational decode of a single BCD digit, with forced blanking.
// Ports:
//   bcd   in  4  BCD digit (values above 9 decode to all segments off)
//   blank in  1  1 forces all segments off
//   seg   out 7  segment data, bit0=a .. bit6=g, 1 = lit
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_segment_bcd_counter.sv
// rtl/seven_segment_bcd_counter.sv - multi-digit BCD up/down counter with seven-segment outputs
// Purpose: prescaled BCD up/down counter driving DIGITS displays.
// Ports:
//   CLK_50   in  1         system clock
//   RESET_N  in  1         asynchronous active-low reset
//   EN       in  1         runs prescaler and allows steps
//   UP_DN    in  1         1 = count up, 0 = count down (sampled on the step)
//   CLEAR    in  1         synchronous clear of count and prescaler (highest priority)
//   LOAD     in  1         synchronous load of LOAD_VAL (invalid digits stored as 0)
//   LOAD_VAL in  4*DIGITS  load value, digit 0 in [3:0]
//   BCD_VAL  out 4*DIGITS  registered count
//   HEX      out 7*DIGITS  segments, digit k in [7k+6:7k]
//   TICK     out 1         one-cycle pulse aligned with each new count
//   WRAP     out 1         one-cycle pulse when a step wraps the whole count
module seven_segment_bcd_counter
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 3,
  parameter int TICK_DIV      = 50000000,
  parameter int BLANK_LEADING = 0
) (
  input  logic                  CLK_50,
  input  logic                  RESET_N,
  input  logic                  EN,
  input  logic                  UP_DN,
  input  logic                  CLEAR,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   BCD_VAL,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  TICK,
  output logic                  WRAP
);

  // A TICK_DIV of 1 still needs a 1-bit register to keep the code uniform.
  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]         presc;
  logic                  step;
  logic [4*DIGITS-1:0]   bcd_step;
  logic [4*DIGITS-1:0]   load_clean;
  logic                  ripple;
  logic [DIGITS-1:0]     blank;
  logic                  upper_zero;

  assign step = EN && (presc == PRESC_LAST);

  // Ripple carry/borrow through the digits; if it survives past the top
  // digit every digit was at its edge value and the count wraps.
  always_comb begin
    bcd_step   = BCD_VAL;
    load_clean = '0;
    ripple     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      load_clean[4*i +: 4] = bcd_valid(LOAD_VAL[4*i +: 4]) ? LOAD_VAL[4*i +: 4] : 4'd0;
      if (ripple) begin
        if (UP_DN) begin
          if (BCD_VAL[4*i +: 4] >= BCD_MAX) begin
            bcd_step[4*i +: 4] = 4'd0;
          end else begin
            bcd_step[4*i +: 4] = BCD_VAL[4*i +: 4] + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (BCD_VAL[4*i +: 4] == 4'd0) begin
            bcd_step[4*i +: 4] = BCD_MAX;
          end else begin
            bcd_step[4*i +: 4] = BCD_VAL[4*i +: 4] - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc   <= '0;
      BCD_VAL <= '0;
      TICK    <= 1'b0;
      WRAP    <= 1'b0;
    end else if (CLEAR) begin
      presc   <= '0;
      BCD_VAL <= '0;
      TICK    <= 1'b0;
      WRAP    <= 1'b0;
    end else if (LOAD) begin
      presc   <= '0;
      BCD_VAL <= load_clean;
      TICK    <= 1'b0;
      WRAP    <= 1'b0;
    end else begin
      TICK <= step;
      WRAP <= step && ripple;
      if (step) begin
        presc   <= '0;
        BCD_VAL <= bcd_step;
      end else if (EN) begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Scan from the top digit down: a digit is a leading zero while every
  // digit above it (and itself) is zero. Digit 0 always stays visible.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (BCD_VAL[4*k +: 4] == 4'd0);
      blank[k]   = (BLANK_LEADING != 0) && (k != 0) && upper_zero;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_decoder u_dec (
      .bcd   (BCD_VAL[4*g +: 4]),
      .blank (blank[g]),
      .seg   (HEX[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_seven_segment_bcd_counter.sv
// tb/tb_seven_segment_bcd_counter.sv - table-driven bench for seven_segment_bcd_counter
module tb_seven_segment_bcd_counter;

  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011;
  localparam logic [6:0] S5 = 7'b1101101, S6 = 7'b1111101, S7 = 7'b0000111;
  localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1101111, SB = 7'b0000000;

  logic        CLK_50 = 1'b0;
  logic        RESET_N, EN, UP_DN, CLEAR, LOAD;
  logic [11:0] LOAD_VAL;

  logic [11:0] bcd_a, bcd_b;
  logic [20:0] hex_a, hex_b;
  logic        tick_a, wrap_a, tick_b, wrap_b;
  logic [3:0]  bcd_c;
  logic [6:0]  hex_c;
  logic        tick_c, wrap_c;

  int tests = 0;
  int fails = 0;

  always #5 CLK_50 = ~CLK_50;

  seven_segment_bcd_counter #(.DIGITS(3), .TICK_DIV(4), .BLANK_LEADING(0)) dut_a (
    .CLK_50(CLK_50), .RESET_N(RESET_N), .EN(EN), .UP_DN(UP_DN), .CLEAR(CLEAR),
    .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .BCD_VAL(bcd_a), .HEX(hex_a),
    .TICK(tick_a), .WRAP(wrap_a));

  seven_segment_bcd_counter #(.DIGITS(3), .TICK_DIV(4), .BLANK_LEADING(1)) dut_b (
    .CLK_50(CLK_50), .RESET_N(RESET_N), .EN(EN), .UP_DN(UP_DN), .CLEAR(CLEAR),
    .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .BCD_VAL(bcd_b), .HEX(hex_b),
    .TICK(tick_b), .WRAP(wrap_b));

  seven_segment_bcd_counter #(.DIGITS(1), .TICK_DIV(1), .BLANK_LEADING(0)) dut_c (
    .CLK_50(CLK_50), .RESET_N(RESET_N), .EN(EN), .UP_DN(UP_DN), .CLEAR(CLEAR),
    .LOAD(LOAD), .LOAD_VAL(LOAD_VAL[3:0]), .BCD_VAL(bcd_c), .HEX(hex_c),
    .TICK(tick_c), .WRAP(wrap_c));

  typedef struct {
    logic        clear, load, en, up;
    logic [11:0] lv;
    int          n;
    logic [11:0] bcd;
    logic        tick, wrap;
    logic [6:0]  hex0;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic l, logic e, logic u, logic [11:0] lv, int n,
                              logic [11:0] bcd, logic t, logic w, logic [6:0] h0);
    vec_t v;
    v.clear = c; v.load = l; v.en = e; v.up = u; v.lv = lv; v.n = n;
    v.bcd = bcd; v.tick = t; v.wrap = w; v.hex0 = h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic u,
                       input logic [11:0] lv);
    CLEAR = c; LOAD = l; EN = e; UP_DN = u; LOAD_VAL = lv;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK_50);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    drive(0, 0, 0, 1, 12'h000);

    // clear, load, en, up, load_val, edges, bcd, tick, wrap, hex digit 0
    vecs.push_back(mk(0,0,1,1,12'h000,3, 12'h000,0,0,S0));
    vecs.push_back(mk(0,0,1,1,12'h000,1, 12'h001,1,0,S1));
    vecs.push_back(mk(0,0,1,1,12'h000,1, 12'h001,0,0,S1));
    vecs.push_back(mk(0,0,1,1,12'h000,3, 12'h002,1,0,S2));
    vecs.push_back(mk(0,1,1,1,12'h998,1, 12'h998,0,0,S8));
    vecs.push_back(mk(0,0,1,1,12'h000,4, 12'h999,1,0,S9));
    vecs.push_back(mk(0,0,1,1,12'h000,4, 12'h000,1,1,S0));
    vecs.push_back(mk(0,0,1,1,12'h000,1, 12'h000,0,0,S0));
    vecs.push_back(mk(0,1,1,0,12'h100,1, 12'h100,0,0,S0));
    vecs.push_back(mk(0,0,1,0,12'h000,4, 12'h099,1,0,S9));
    vecs.push_back(mk(0,1,1,0,12'h000,1, 12'h000,0,0,S0));
    vecs.push_back(mk(0,0,1,0,12'h000,4, 12'h999,1,1,S9));
    vecs.push_back(mk(0,1,1,0,12'h0A5,1, 12'h005,0,0,S5));
    vecs.push_back(mk(0,0,1,1,12'h000,3, 12'h005,0,0,S5));
    vecs.push_back(mk(1,1,1,1,12'h123,1, 12'h000,0,0,S0));
    vecs.push_back(mk(0,0,1,1,12'h000,3, 12'h000,0,0,S0));
    vecs.push_back(mk(0,1,1,1,12'h456,1, 12'h456,0,0,S6));
    vecs.push_back(mk(0,0,1,1,12'h000,4, 12'h457,1,0,S7));
    vecs.push_back(mk(0,0,1,1,12'h000,2, 12'h457,0,0,S7));
    vecs.push_back(mk(0,0,0,1,12'h000,10,12'h457,0,0,S7));
    vecs.push_back(mk(0,0,1,1,12'h000,1, 12'h457,0,0,S7));
    vecs.push_back(mk(0,0,1,1,12'h000,1, 12'h458,1,0,S8));
    vecs.push_back(mk(0,0,1,0,12'h000,2, 12'h458,0,0,S8));
    vecs.push_back(mk(0,0,1,1,12'h000,1, 12'h458,0,0,S8));
    vecs.push_back(mk(0,0,1,0,12'h000,1, 12'h457,1,0,S7));

    cycles(2);
    chk("reset bcd", 32'(bcd_a), 32'h000);
    chk("reset tick", 32'(tick_a), 32'd0);
    chk("reset wrap", 32'(wrap_a), 32'd0);
    chk("reset hex", 32'(hex_a), 32'({S0, S0, S0}));
    chk("reset hex blanked", 32'(hex_b), 32'({SB, SB, S0}));

    drive(0, 0, 1, 1, 12'h000);
    #2 RESET_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clear, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv);
      cycles(vecs[i].n);
      chk($sformatf("row%0d bcd", i),  32'(bcd_a),      32'(vecs[i].bcd));
      chk($sformatf("row%0d tick", i), 32'(tick_a),     32'(vecs[i].tick));
      chk($sformatf("row%0d wrap", i), 32'(wrap_a),     32'(vecs[i].wrap));
      chk($sformatf("row%0d hex0", i), 32'(hex_a[6:0]), 32'(vecs[i].hex0));
    end

    // Leading-zero blanking against the unblanked instance
    drive(0, 1, 0, 1, 12'h007); cycles(1);
    chk("hex 007", 32'(hex_a), 32'({S0, S0, S7}));
    chk("blank 007", 32'(hex_b), 32'({SB, SB, S7}));
    drive(1, 0, 0, 1, 12'h000); cycles(1);
    chk("blank 000", 32'(hex_b), 32'({SB, SB, S0}));
    drive(0, 1, 0, 1, 12'h0A5); cycles(1);
    chk("blank 0A5", 32'(hex_b), 32'({SB, SB, S5}));
    drive(0, 1, 0, 1, 12'h070); cycles(1);
    chk("blank 070", 32'(hex_b), 32'({SB, S7, S0}));
    drive(0, 1, 0, 1, 12'h500); cycles(1);
    chk("blank 500", 32'(hex_b), 32'({S5, S0, S0}));

    // TICK_DIV=1 single digit: steps every enabled cycle
    drive(1, 0, 0, 1, 12'h000); cycles(1);
    chk("div1 clear", 32'(bcd_c), 32'd0);
    drive(0, 0, 1, 1, 12'h000); cycles(1);
    chk("div1 step bcd", 32'(bcd_c), 32'd1);
    chk("div1 step tick", 32'(tick_c), 32'd1);
    cycles(8);
    chk("div1 nine bcd", 32'(bcd_c), 32'd9);
    chk("div1 nine wrap", 32'(wrap_c), 32'd0);
    cycles(1);
    chk("div1 wrap bcd", 32'(bcd_c), 32'd0);
    chk("div1 wrap pulse", 32'(wrap_c), 32'd1);
    chk("div1 wrap hex", 32'(hex_c), 32'(S0));
    drive(0, 0, 1, 0, 12'h000); cycles(1);
    chk("div1 down bcd", 32'(bcd_c), 32'd9);
    chk("div1 down wrap", 32'(wrap_c), 32'd1);

    // Asynchronous reset between edges while TICK is high
    drive(0, 1, 1, 1, 12'h321); cycles(1);
    drive(0, 0, 1, 1, 12'h000); cycles(4);
    chk("pre-reset bcd", 32'(bcd_a), 32'h322);
    chk("pre-reset tick", 32'(tick_a), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("async reset bcd", 32'(bcd_a), 32'h000);
    chk("async reset tick", 32'(tick_a), 32'd0);
    chk("async reset hex", 32'(hex_a), 32'({S0, S0, S0}));
    #2 RESET_N = 1'b1;
    cycles(3);
    chk("post-reset no step", 32'(bcd_a), 32'h000);
    chk("post-reset no tick", 32'(tick_a), 32'd0);
    cycles(1);
    chk("post-reset first step", 32'(bcd_a), 32'h001);
    chk("post-reset first tick", 32'(tick_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
